axis_pkt_gen: RTL
=================

# axis_pkt_gen

- AXI4-Stream packet transmitter: on a start command, emits `num_pkts` packets of `pkt_len` beats each.
- Beats carry a counting data pattern starting at `seed`; `tlast` marks the final beat of every packet.
- Acts as the upstream source for the AXI4-Stream FIFO (drives its `s_axis_*` slave port), replacing behavioural bench stimulus with synthesizable traffic for board-level loopback and throughput tests.

## Interface
Parameters:
- DATA_W, 8, tdata width; the data counter wraps modulo 2^DATA_W
- LEN_W, 8, width of the packet-length field
- GAP_W, 4, width of the inter-packet gap field

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  synchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- pkt_len  in  LEN_W  beats per packet; 0 = start ignored
- num_pkts  in  8  packets per command; 0 = start ignored
- gap  in  GAP_W  idle cycles (tvalid=0) between packets
- seed  in  DATA_W  tdata of first beat
- m_axis_tdata  out  DATA_W  beat data
- m_axis_tvalid  out  1  beat valid
- m_axis_tlast  out  1  last beat of packet
- m_axis_tready  in  1  sink ready
- busy  out  1  command in progress
- done  out  1  one-cycle pulse after final beat accepted
- pkt_cnt  out  8  packets fully accepted in current/last command

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE -> SEND on start=1 with pkt_len!=0 and num_pkts!=0.
  - pkt_len, num_pkts, gap and seed are latched on that edge; later input changes have no effect.
  - pkt_cnt clears to 0 on that edge.
- SEND: tvalid=1; a beat is accepted when tvalid && tready.
  - Each accepted beat increments tdata by 1 (wrapping) and advances the beat counter.
  - tlast=1 exactly on beat pkt_len of each packet.
- On accepted tlast: pkt_cnt increments.
  - If pkt_cnt reaches num_pkts: go to IDLE, pulse done.
  - Else if gap=0: stay in SEND; the next packet's first beat is presented the following cycle with tvalid continuously high.
  - Else: go to GAP.
- GAP: tvalid=0 for exactly `gap` cycles, then SEND.
- The tdata sequence is continuous across packets within a command; it restarts at the latched seed only on a new command.
- AXI rule: once tvalid=1, tdata/tlast/tvalid hold stable until the handshake; tvalid never drops without a handshake.
- start while busy=1 is ignored.
- pkt_len=1: every beat has tlast=1.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, done=0, pkt_cnt=0; FSM=IDLE. Reset mid-packet aborts immediately; no done pulse.
- All outputs are registered; no combinational path from tready to any output.
- start sampled at edge N -> tvalid=1, busy=1, tdata=seed from cycle N+1.
- Sustained throughput with tready=1 and gap=0: 1 beat/cycle, including across packet boundaries.
- Final handshake at edge M -> cycle M+1: busy=0, done=1, tvalid=0. done falls at M+2.
- Earliest new command: start sampled at edge M+1 is accepted.
- tready low for any number of cycles stalls all counters; no beat is lost or duplicated.

## Configuration
- AXIS_PKT_GEN_THROTTLE_EN defined: adds input `throttle [3:0]`.
  - After each accepted beat that is not tlast, tvalid is held 0 for `throttle` cycles before the next beat of the same packet.
  - throttle=0 means back-to-back beats.
  - Deassertion happens only after a handshake, so the AXI stability rule is preserved.
  - `throttle` is latched with the other fields at start.
- Not defined: port absent; beats within a packet are always back-to-back when tready=1.

## Test plan
- Basic: seed=0x00, pkt_len=20, num_pkts=1, gap=0, tready=1 -> tdata 0..19 on cycles N+1..N+20; tlast only on 19; done at N+21; pkt_cnt=1.
- Back-to-back: seed=0xFE, pkt_len=3, num_pkts=3, gap=0 -> 9 consecutive beats FE,FF,00,01..06 (wrap); tlast on beats 3, 6, 9; tvalid never low in between.
- Gap: pkt_len=2, num_pkts=2, gap=4 -> exactly 4 tvalid=0 cycles between the two packets; done after beat 4.
- Backpressure: pkt_len=20, tready low for 8 cycles after beat 10 and for 5 cycles after beat 25 of a 2-packet command -> tdata/tlast stable while stalled; the sink receives a gap-free 0..39 sequence.
- Corners: start with pkt_len=0 -> busy stays 0. A second start while busy -> ignored. aresetn=0 mid-packet -> all outputs at reset values next cycle; a following start restarts at seed.
- Throttle (macro on): throttle=2, pkt_len=4, tready=1 -> beats spaced 3 cycles apart; tvalid never falls before a handshake.

Source files
------------

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream counting-pattern packet source: emits num_pkts packets of pkt_len beats per start command.
// Optional define AXIS_PKT_GEN_THROTTLE_EN adds a per-beat idle spacing input `throttle`.
module axis_pkt_gen #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [7:0]        num_pkts,
  input  logic [GAP_W-1:0]  gap,
  input  logic [DATA_W-1:0] seed,
`ifdef AXIS_PKT_GEN_THROTTLE_EN
  input  logic [3:0]        throttle,
`endif
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        pkt_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  logic [1:0]        state;
  logic [LEN_W-1:0]  len_lat;
  logic [7:0]        num_lat;
  logic [GAP_W-1:0]  gap_lat;
  logic [LEN_W-1:0]  beat_idx;
  logic [GAP_W-1:0]  gap_left;
  logic [3:0]        thr_left;
  logic [3:0]        thr_lat;
  logic [7:0]        pkt_next;
  logic              go;
  logic              accept;

  assign go       = (state == IDLE) && start && (pkt_len != '0) && (num_pkts != '0);
  assign accept   = m_axis_tvalid && m_axis_tready;
  assign pkt_next = pkt_cnt + 8'd1;

`ifdef AXIS_PKT_GEN_THROTTLE_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      thr_lat <= 4'd0;
    end else if (go) begin
      thr_lat <= throttle;
    end
  end
`else
  assign thr_lat = 4'd0;
`endif

  // beat_idx is the 1-based position of the beat currently presented in its packet.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      len_lat       <= '0;
      num_lat       <= '0;
      gap_lat       <= '0;
      beat_idx      <= '0;
      gap_left      <= '0;
      thr_left      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkt_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state         <= SEND;
            len_lat       <= pkt_len;
            num_lat       <= num_pkts;
            gap_lat       <= gap;
            beat_idx      <= LEN_ONE;
            m_axis_tdata  <= seed;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (pkt_len == LEN_ONE);
            busy          <= 1'b1;
            pkt_cnt       <= '0;
          end
        end

        SEND: begin
          if (accept) begin
            m_axis_tdata <= m_axis_tdata + DATA_ONE;
            if (m_axis_tlast) begin
              pkt_cnt  <= pkt_next;
              beat_idx <= LEN_ONE;
              if (pkt_next == num_lat) begin
                state         <= IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b1;
              end else if (gap_lat == '0) begin
                m_axis_tlast <= (len_lat == LEN_ONE);
              end else begin
                state         <= GAP;
                gap_left      <= gap_lat;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
              end
            end else begin
              beat_idx     <= beat_idx + LEN_ONE;
              m_axis_tlast <= ((beat_idx + LEN_ONE) == len_lat);
              // Throttle only ever drops tvalid right after a handshake.
              if (thr_lat != 4'd0) begin
                m_axis_tvalid <= 1'b0;
                thr_left      <= thr_lat;
              end
            end
          end else if (!m_axis_tvalid) begin
            thr_left <= thr_left - 4'd1;
            if (thr_left == 4'd1) begin
              m_axis_tvalid <= 1'b1;
            end
          end
        end

        GAP: begin
          gap_left <= gap_left - GAP_ONE;
          if (gap_left == GAP_ONE) begin
            state         <= SEND;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (len_lat == LEN_ONE);
          end
        end

        default: begin
          state         <= IDLE;
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule
